// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and fetch state encodings for the IF stage
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic                   RstEnable = 1'b1;

    // All-zero word doubles as the bubble presented downstream
    localparam logic [InstBus-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_REQ   = 2'b01,
        IF_VALID = 2'b10
    } if_state_e;

    // Fetch addresses are always word aligned; low bits of any target are dropped
    function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction memory req/ack bus between fetch stage and memory
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   mem_req_o;
    logic [InstAddrBus-1:0] mem_addr_o;
    logic                   mem_ack_i;
    logic [InstBus-1:0]     mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with PC, req/ack fetch FSM and redirects (optional IF_PERF_CNT_EN counters)
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned            PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_address_i,
    if_fetch_if.master             mem,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   stallreq_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam logic [InstAddrBus-1:0] STEP = 32'(PC_STEP);

    if_state_e              state, state_n;
    logic [InstAddrBus-1:0] pc, pc_n;
    logic [InstAddrBus-1:0] fetch_addr, fetch_addr_n;
    logic                   redirect_pend, redirect_pend_n;
    logic [InstAddrBus-1:0] redirect_tgt, redirect_tgt_n;
    logic [InstAddrBus-1:0] pc_q, pc_q_n;
    logic [InstBus-1:0]     inst_q, inst_q_n;
    logic [InstAddrBus-1:0] br_tgt;
    logic [InstAddrBus-1:0] redirect_addr;
    logic                   redirect_now;

    // Only bit 0 of the stall vector concerns this stage
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall[5:1];

    assign br_tgt       = align_word(branch_target_address_i);
    assign redirect_now = branch_flag_i || redirect_pend;

    // State and datapath registers; reset wins over any ack in the same cycle
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state         <= IF_IDLE;
            pc            <= RESET_PC;
            fetch_addr    <= ZeroWord;
            redirect_pend <= 1'b0;
            redirect_tgt  <= ZeroWord;
            pc_q          <= ZeroWord;
            inst_q        <= NOP_INST;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            fetch_addr    <= fetch_addr_n;
            redirect_pend <= redirect_pend_n;
            redirect_tgt  <= redirect_tgt_n;
            pc_q          <= pc_q_n;
            inst_q        <= inst_q_n;
        end
    end

    // Next-state and datapath updates for the IDLE -> REQ <-> VALID fetch loop
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        fetch_addr_n    = fetch_addr;
        redirect_pend_n = redirect_pend;
        redirect_tgt_n  = redirect_tgt;
        pc_q_n          = pc_q;
        inst_q_n        = inst_q;
        redirect_addr   = branch_flag_i ? br_tgt : redirect_tgt;

        case (state)
            IF_IDLE: begin
                state_n = IF_REQ;
                if (branch_flag_i) begin
                    pc_n         = br_tgt;
                    fetch_addr_n = br_tgt;
                end else begin
                    fetch_addr_n = pc;
                end
            end

            IF_REQ: begin
                if (mem.mem_ack_i) begin
                    if (redirect_now) begin
                        // Returned word belongs to the wrong path: drop it and refetch at target
                        pc_n            = redirect_addr;
                        fetch_addr_n    = redirect_addr;
                        redirect_pend_n = 1'b0;
                        pc_q_n          = ZeroWord;
                        inst_q_n        = NOP_INST;
                        state_n         = IF_REQ;
                    end else begin
                        pc_q_n   = fetch_addr;
                        inst_q_n = mem.mem_rdata_i;
                        pc_n     = fetch_addr + STEP;
                        state_n  = IF_VALID;
                    end
                end else if (branch_flag_i) begin
                    // Request must stay stable until ack, so remember the redirect
                    redirect_pend_n = 1'b1;
                    redirect_tgt_n  = br_tgt;
                end
            end

            IF_VALID: begin
                if (stall[0]) begin
                    if (branch_flag_i) begin
                        redirect_pend_n = 1'b1;
                        redirect_tgt_n  = br_tgt;
                    end
                end else begin
                    if (branch_flag_i) begin
                        fetch_addr_n = br_tgt;
                        pc_n         = br_tgt;
                    end else if (redirect_pend) begin
                        fetch_addr_n = redirect_tgt;
                        pc_n         = redirect_tgt;
                    end else begin
                        fetch_addr_n = pc;
                    end
                    redirect_pend_n = 1'b0;
                    state_n         = IF_REQ;
                end
            end

            default: begin
                state_n = IF_IDLE;
            end
        endcase
    end

    // Bus and pipeline-register outputs; anything but VALID presents a bubble
    always_comb begin
        mem.mem_req_o  = (state == IF_REQ);
        mem.mem_addr_o = fetch_addr;
        if_pc          = (state == IF_VALID) ? pc_q : ZeroWord;
        if_inst        = (state == IF_VALID) ? inst_q : NOP_INST;
        stallreq_if    = (state == IF_REQ) && !(mem.mem_ack_i && !redirect_now);
    end

`ifdef IF_PERF_CNT_EN
    // Count every accepted ack (including discarded ones) and every stall-request cycle
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if ((state == IF_REQ) && mem.mem_ack_i) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stallreq_if) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
